// File: rtl/mem_interface.sv
// Memory access sequencer between the MAR/MDR and a word-addressed synchronous RAM.
// Each read or write holds the RAM strobe for WAIT_STATES cycles, then completes.
module mem_interface #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mar_addr,
  input  logic [DATA_W-1:0] mdr_data,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mdr_read,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                op_rd_r, op_rd_s;
  logic [ADDR_W-1:0]   ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0]   ram_wdata_r, ram_wdata_s;
  logic                ram_we_r, ram_we_s;
  logic                ram_re_r, ram_re_s;
  logic [DATA_W-1:0]   mdatain_r, mdatain_s;
  logic                mdr_read_r, mdr_read_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                err_r, err_s;

  // Only the low ADDR_W bits of the MAR address the RAM.
  logic unused_mar_s;
  assign unused_mar_s = ^mar_addr[31:ADDR_W];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    op_rd_s     = op_rd_r;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    mdatain_s   = mdatain_r;
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    mdr_read_s  = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_rd ^ mem_wr) begin
          state_s    = ACCESS;
          op_rd_s    = mem_rd;
          ram_addr_s = mar_addr[ADDR_W-1:0];
          cnt_s      = CNT_INIT;
          ram_re_s   = mem_rd;
          ram_we_s   = mem_wr;
          busy_s     = 1'b1;
          if (mem_wr) begin
            ram_wdata_s = mdr_data;
          end else begin
            ram_wdata_s = ram_wdata_r;
          end
        end else if (mem_rd && mem_wr) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      ACCESS: begin
        busy_s = 1'b1;
        // Strobe stays up until the counter has run out; this edge then closes it.
        if (cnt_r == 4'd0) begin
          state_s    = COMPLETE;
          done_s     = 1'b1;
          mdr_read_s = op_rd_r;
          if (op_rd_r) begin
            mdatain_s = ram_rdata;
          end else begin
            mdatain_s = mdatain_r;
          end
        end else begin
          cnt_s    = cnt_r - 4'd1;
          ram_re_s = op_rd_r;
          ram_we_s = ~op_rd_r;
        end
      end
      COMPLETE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; clear wins over every request.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      op_rd_r     <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_we_r    <= 1'b0;
      ram_re_r    <= 1'b0;
      mdatain_r   <= '0;
      mdr_read_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      op_rd_r     <= op_rd_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
      ram_we_r    <= ram_we_s;
      ram_re_r    <= ram_re_s;
      mdatain_r   <= mdatain_s;
      mdr_read_r  <= mdr_read_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign ram_we    = ram_we_r;
  assign ram_re    = ram_re_r;
  assign Mdatain   = mdatain_r;
  assign mdr_read  = mdr_read_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: one instance with 1 wait state, one with 3,
// each backed by a small synchronous RAM model.
module tb_mem_interface;

  logic        clock;
  logic        clear;
  logic [31:0] mar;
  logic [31:0] mdr;

  logic        a_rd, a_wr, a_we, a_re, a_mdr_read, a_busy, a_done, a_err;
  logic [31:0] a_rdata, a_wdata, a_mdatain;
  logic [8:0]  a_addr;
  logic        b_rd, b_wr, b_we, b_re, b_mdr_read, b_busy, b_done, b_err;
  logic [31:0] b_rdata, b_wdata, b_mdatain;
  logic [8:0]  b_addr;

  logic [31:0] mem_a [0:511];
  logic [31:0] mem_b [0:511];

  int n_cmp = 0;
  int n_mis = 0;

  mem_interface #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(1)) u_a (
    .clock(clock), .clear(clear), .mem_rd(a_rd), .mem_wr(a_wr), .mar_addr(mar),
    .mdr_data(mdr), .ram_rdata(a_rdata), .ram_addr(a_addr), .ram_wdata(a_wdata),
    .ram_we(a_we), .ram_re(a_re), .Mdatain(a_mdatain), .mdr_read(a_mdr_read),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  mem_interface #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(3)) u_b (
    .clock(clock), .clear(clear), .mem_rd(b_rd), .mem_wr(b_wr), .mar_addr(mar),
    .mdr_data(mdr), .ram_rdata(b_rdata), .ram_addr(b_addr), .ram_wdata(b_wdata),
    .ram_we(b_we), .ram_re(b_re), .Mdatain(b_mdatain), .mdr_read(b_mdr_read),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM models: write on the clock edge, read data valid while the read strobe is high
  always @(posedge clock) begin
    if (a_we) mem_a[a_addr] <= a_wdata;
    if (b_we) mem_b[b_addr] <= b_wdata;
  end
  assign a_rdata = a_re ? mem_a[a_addr] : 32'h0;
  assign b_rdata = b_re ? mem_b[b_addr] : 32'h0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
    mar = 32'h0; mdr = 32'h0;
    tick(); tick();
    n_cmp++; if ({a_we, a_re, a_mdr_read, a_busy, a_done, a_err} !== 6'b0) begin n_mis++; $display("FAIL reset_a_ctl got %b want 000000", {a_we, a_re, a_mdr_read, a_busy, a_done, a_err}); end
    n_cmp++; if ({a_addr, a_wdata, a_mdatain} !== 73'h0) begin n_mis++; $display("FAIL reset_a_data got %h want 0", {a_addr, a_wdata, a_mdatain}); end
    n_cmp++; if ({b_we, b_re, b_mdr_read, b_busy, b_done, b_err} !== 6'b0) begin n_mis++; $display("FAIL reset_b_ctl got %b want 000000", {b_we, b_re, b_mdr_read, b_busy, b_done, b_err}); end
    clear = 1'b0;
    tick();
  endtask

  task automatic test_write_ws1();
    a_wr = 1'b1; mar = 32'h0000_0005; mdr = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if ({a_we, a_re, a_busy, a_done} !== 4'b1010) begin n_mis++; $display("FAIL wr1_strobe got we/re/busy/done=%b want 1010", {a_we, a_re, a_busy, a_done}); end
    n_cmp++; if (a_addr !== 9'h005) begin n_mis++; $display("FAIL wr1_addr got %h want 005", a_addr); end
    n_cmp++; if (a_wdata !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL wr1_wdata got %h want deadbeef", a_wdata); end
    a_wr = 1'b0; mdr = 32'h1111_1111;
    tick();
    n_cmp++; if ({a_we, a_done, a_mdr_read, a_busy} !== 4'b0101) begin n_mis++; $display("FAIL wr1_done got we/done/mdr_read/busy=%b want 0101", {a_we, a_done, a_mdr_read, a_busy}); end
    n_cmp++; if (mem_a[5] !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL wr1_commit got %h want deadbeef", mem_a[5]); end
    tick();
    n_cmp++; if ({a_busy, a_done} !== 2'b00) begin n_mis++; $display("FAIL wr1_idle got busy/done=%b want 00", {a_busy, a_done}); end
  endtask

  task automatic test_read_ws1();
    a_rd = 1'b1; mar = 32'h0000_0005;
    tick();
    n_cmp++; if ({a_re, a_we, a_busy} !== 3'b101) begin n_mis++; $display("FAIL rd1_strobe got re/we/busy=%b want 101", {a_re, a_we, a_busy}); end
    a_rd = 1'b0;
    tick();
    n_cmp++; if ({a_re, a_mdr_read, a_done, a_busy} !== 4'b0111) begin n_mis++; $display("FAIL rd1_done got re/mdr_read/done/busy=%b want 0111", {a_re, a_mdr_read, a_done, a_busy}); end
    n_cmp++; if (a_mdatain !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL rd1_data got %h want deadbeef", a_mdatain); end
    tick();
    n_cmp++; if ({a_mdr_read, a_done, a_mdatain} !== {2'b00, 32'hDEAD_BEEF}) begin n_mis++; $display("FAIL rd1_hold got %b/%h want 00/deadbeef", {a_mdr_read, a_done}, a_mdatain); end
  endtask

  task automatic test_read_ws3();
    b_wr = 1'b1; mar = 32'h0000_0007; mdr = 32'h1234_5678;
    tick();
    b_wr = 1'b0;
    repeat (4) tick();
    n_cmp++; if (mem_b[7] !== 32'h1234_5678) begin n_mis++; $display("FAIL wr3_commit got %h want 12345678", mem_b[7]); end
    b_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({b_re, b_busy, b_done} !== 3'b110) begin n_mis++; $display("FAIL rd3_access%0d got re/busy/done=%b want 110", i, {b_re, b_busy, b_done}); end
    end
    tick();
    n_cmp++; if ({b_re, b_mdr_read, b_done, b_busy} !== 4'b0111) begin n_mis++; $display("FAIL rd3_done got re/mdr_read/done/busy=%b want 0111", {b_re, b_mdr_read, b_done, b_busy}); end
    n_cmp++; if (b_mdatain !== 32'h1234_5678) begin n_mis++; $display("FAIL rd3_data got %h want 12345678", b_mdatain); end
    tick();
    n_cmp++; if ({b_re, b_busy, b_done} !== 3'b000) begin n_mis++; $display("FAIL rd3_idle got re/busy/done=%b want 000", {b_re, b_busy, b_done}); end
    tick();
    n_cmp++; if ({b_re, b_busy} !== 2'b11) begin n_mis++; $display("FAIL rd3_resample got re/busy=%b want 11", {b_re, b_busy}); end
    b_rd = 1'b0;
    repeat (4) tick();
    n_cmp++; if ({b_re, b_busy, b_done} !== 3'b000) begin n_mis++; $display("FAIL rd3_drain got re/busy/done=%b want 000", {b_re, b_busy, b_done}); end
  endtask

  task automatic test_illegal();
    a_rd = 1'b1; a_wr = 1'b1; mar = 32'h0000_0011;
    tick();
    n_cmp++; if ({a_err, a_re, a_we, a_busy} !== 4'b1000) begin n_mis++; $display("FAIL ill_err got err/re/we/busy=%b want 1000", {a_err, a_re, a_we, a_busy}); end
    a_rd = 1'b0; a_wr = 1'b0;
    tick();
    n_cmp++; if ({a_err, a_re, a_we, a_busy} !== 4'b0000) begin n_mis++; $display("FAIL ill_after got err/re/we/busy=%b want 0000", {a_err, a_re, a_we, a_busy}); end
  endtask

  task automatic test_clear_abort();
    b_wr = 1'b1; mar = 32'h0000_0009; mdr = 32'hAAAA_5555;
    tick();
    b_wr = 1'b0;
    tick();
    n_cmp++; if ({b_we, b_busy} !== 2'b11) begin n_mis++; $display("FAIL abort_pre got we/busy=%b want 11", {b_we, b_busy}); end
    clear = 1'b1;
    tick();
    n_cmp++; if ({b_we, b_re, b_mdr_read, b_busy, b_done, b_err} !== 6'b0) begin n_mis++; $display("FAIL abort_ctl got %b want 000000", {b_we, b_re, b_mdr_read, b_busy, b_done, b_err}); end
    n_cmp++; if ({b_addr, b_wdata, b_mdatain} !== 73'h0) begin n_mis++; $display("FAIL abort_data got %h want 0", {b_addr, b_wdata, b_mdatain}); end
    clear = 1'b0;
    tick();
    n_cmp++; if ({b_done, b_busy, b_we} !== 3'b000) begin n_mis++; $display("FAIL abort_nodone got done/busy/we=%b want 000", {b_done, b_busy, b_we}); end
    b_rd = 1'b1; mar = 32'h0000_0007;
    tick();
    b_rd = 1'b0;
    tick(); tick();
    n_cmp++; if ({b_re, b_done} !== 2'b10) begin n_mis++; $display("FAIL abort_rd_access got re/done=%b want 10", {b_re, b_done}); end
    tick();
    n_cmp++; if ({b_done, b_mdr_read, b_mdatain} !== {2'b11, 32'h1234_5678}) begin n_mis++; $display("FAIL abort_rd_done got %b/%h want 11/12345678", {b_done, b_mdr_read}, b_mdatain); end
    tick();
  endtask

  task automatic test_addr_trunc();
    a_wr = 1'b1; mar = 32'h0000_0203; mdr = 32'h0BAD_F00D;
    tick();
    n_cmp++; if (a_addr !== 9'h003) begin n_mis++; $display("FAIL trunc_wr_addr got %h want 003", a_addr); end
    a_wr = 1'b0;
    tick(); tick();
    a_rd = 1'b1; mar = 32'hFFFF_FE03;
    tick();
    n_cmp++; if ({a_re, a_addr} !== {1'b1, 9'h003}) begin n_mis++; $display("FAIL trunc_rd_addr got re=%b addr=%h want 1/003", a_re, a_addr); end
    a_rd = 1'b0;
    tick();
    n_cmp++; if ({a_done, a_mdatain} !== {1'b1, 32'h0BAD_F00D}) begin n_mis++; $display("FAIL trunc_rd_data got %b/%h want 1/0badf00d", a_done, a_mdatain); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_ws1();
    test_read_ws1();
    test_read_ws3();
    test_illegal();
    test_clear_abort();
    test_addr_trunc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
